// File: rtl/rat_pkg.sv
// Shared RAT MCU definitions: PC width, ISR vector, mux-select encodings and
// the stack operation decode used by the return-address stack.
package rat_pkg;

  localparam int PC_W = 10;
  localparam logic [PC_W-1:0] ISR_VEC = 10'h3FF;

  typedef enum logic [1:0] {
    PC_FROM_IMMED = 2'b00,
    PC_FROM_STACK = 2'b01,
    PC_FROM_ISR   = 2'b10
  } pc_mux_sel_t;

  typedef enum logic [1:0] {
    RF_FROM_ALU = 2'b00,
    RF_FROM_SCR = 2'b01,
    RF_FROM_B   = 2'b10,
    RF_FROM_IN  = 2'b11
  } rf_wr_sel_t;

  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stk_op_t;

  function automatic stk_op_t stk_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return STK_PUSH;
      2'b01:   return STK_POP;
      2'b11:   return STK_REPL;
      default: return STK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rat_stack_ram.sv
// Return-address storage: synchronous write, asynchronous read, no reset so it
// maps onto distributed RAM.
module rat_stack_ram #(
  parameter int DEPTH = 32,
  parameter int PC_W  = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [PC_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [PC_W-1:0] rd_data
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rat_ret_addr_stack.sv
// Return-address stack for the RAT MCU: occupancy counter, sticky error flags
// and a zero-latency top-of-stack output feeding the PC mux.
module rat_ret_addr_stack #(
  parameter int DEPTH = 32,
  parameter int PC_W  = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [PC_W-1:0]            PUSH_DATA,
  input  logic                       ERR_CLR,
  output logic [PC_W-1:0]            FROM_STACK,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  import rat_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [CW-1:0]   count_q, count_d, top_idx;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            ovf_err, unf_err;
  logic            empty, full, we;
  logic [AW-1:0]   wr_addr;
  logic [PC_W-1:0] rd_data;
  stk_op_t         op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_MAX);
  assign top_idx = count_q - 1'b1;
  assign op      = stk_op(PUSH, POP);

  // Simultaneous push+pop overwrites the top in place; on an empty stack it
  // degenerates to a plain push but still reports the missing pop.
  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    wr_addr = count_q[AW-1:0];
    ovf_err = 1'b0;
    unf_err = 1'b0;
    case (op)
      STK_PUSH: begin
        if (full) ovf_err = 1'b1;
        else begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      STK_POP: begin
        if (empty) unf_err = 1'b1;
        else       count_d = top_idx;
      end
      STK_REPL: begin
        we = 1'b1;
        if (empty) begin
          unf_err = 1'b1;
          count_d = CW'(1);
        end else begin
          wr_addr = top_idx[AW-1:0];
        end
      end
      default: ;
    endcase
    ovf_d = ovf_err | (ovf_q & ~ERR_CLR);
    unf_d = unf_err | (unf_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  rat_stack_ram #(.DEPTH(DEPTH), .PC_W(PC_W)) u_ram (
    .clk     (CLK),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (PUSH_DATA),
    .rd_addr (top_idx[AW-1:0]),
    .rd_data (rd_data)
  );

  assign FROM_STACK = empty ? '0 : rd_data;
  assign COUNT      = count_q;
  assign EMPTY      = empty;
  assign FULL       = full;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = unf_q;

endmodule

// File: tb/tb_rat_ret_addr_stack.sv
// Bench for rat_ret_addr_stack: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rat_ret_addr_stack;

  localparam int DEPTH = 32;
  localparam int PC_W  = 10;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            PUSH = 1'b0, POP = 1'b0, ERR_CLR = 1'b0;
  logic [PC_W-1:0] PUSH_DATA = '0;
  logic [PC_W-1:0] FROM_STACK;
  logic [5:0]      COUNT;
  logic            EMPTY, FULL, OVERFLOW, UNDERFLOW;

  rat_ret_addr_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PUSH       (PUSH),
    .POP        (POP),
    .PUSH_DATA  (PUSH_DATA),
    .ERR_CLR    (ERR_CLR),
    .FROM_STACK (FROM_STACK),
    .COUNT      (COUNT),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .OVERFLOW   (OVERFLOW),
    .UNDERFLOW  (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [PC_W-1:0] mq[$];
  bit              m_ovf = 0, m_unf = 0;
  bit              chk_en = 0;

  // bench-side program counter that loads FROM_STACK on the pop edge
  logic            pc_ld = 1'b0;
  logic [PC_W-1:0] pc = '0;
  always @(posedge CLK) if (pc_ld) pc <= FROM_STACK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_top();
    return (mq.size() == 0) ? 0 : int'(mq[mq.size()-1]);
  endfunction

  task automatic model_update(input bit p, input bit q, input logic [PC_W-1:0] d, input bit c);
    bit eo = 0, eu = 0;
    if (p && q) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else begin mq.push_back(d); eu = 1; end
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else eo = 1;
    end else if (q) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else eu = 1;
    end
    m_ovf = eo | (m_ovf & !c);
    m_unf = eu | (m_unf & !c);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Single compare process: every negedge, all outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("count",      int'(COUNT),      mq.size());
      chk("empty",      int'(EMPTY),      int'(mq.size() == 0));
      chk("full",       int'(FULL),       int'(mq.size() == DEPTH));
      chk("overflow",   int'(OVERFLOW),   int'(m_ovf));
      chk("underflow",  int'(UNDERFLOW),  int'(m_unf));
      chk("from_stack", int'(FROM_STACK), m_top());
    end
  end

  task automatic step(input bit p, input bit q, input logic [PC_W-1:0] d, input bit c);
    PUSH = p; POP = q; PUSH_DATA = d; ERR_CLR = c;
    @(posedge CLK);
    model_update(p, q, d, c);
    #1;
    PUSH = 0; POP = 0; ERR_CLR = 0;
  endtask

  initial begin
    int pct;
    bit p, q, c;
    // reset and idle
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    chk("rst_count", int'(COUNT), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_top",   int'(FROM_STACK), 0);
    chk("rst_flags", int'({OVERFLOW, UNDERFLOW}), 0);
    chk_en = 1;
    step(0, 0, '0, 0);

    // push three, reset asynchronously mid-sequence
    step(1, 0, 10'h123, 0);
    step(1, 0, 10'h045, 0);
    step(1, 0, 10'h3FF, 0);
    chk("p3_count", int'(COUNT), 3);
    chk("p3_top",   int'(FROM_STACK), 10'h3FF);
    #2 RST = 1;
    #1;
    chk("arst_count", int'(COUNT), 0);
    chk("arst_empty", int'(EMPTY), 1);
    chk("arst_top",   int'(FROM_STACK), 0);
    model_reset();
    @(posedge CLK);
    #1 RST = 0;

    // push three, pop three; top seen in the cycle each pop is applied
    step(1, 0, 10'h123, 0);
    step(1, 0, 10'h045, 0);
    step(1, 0, 10'h3FF, 0);
    chk("lifo_count", int'(COUNT), 3);
    POP = 1; #1 chk("pop1_top", int'(FROM_STACK), 10'h3FF); step(0, 1, '0, 0);
    POP = 1; #1 chk("pop2_top", int'(FROM_STACK), 10'h045); step(0, 1, '0, 0);
    POP = 1; #1 chk("pop3_top", int'(FROM_STACK), 10'h123); step(0, 1, '0, 0);
    chk("lifo_empty", int'(EMPTY), 1);
    chk("lifo_top0",  int'(FROM_STACK), 0);

    // fill, overflow, replace while full, drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, PC_W'(i), 0);
    chk("fill_full", int'(FULL), 1);
    chk("fill_top",  int'(FROM_STACK), 10'h01F);
    step(1, 0, 10'h2AA, 0);
    chk("ovf_flag",  int'(OVERFLOW), 1);
    chk("ovf_count", int'(COUNT), 32);
    chk("ovf_top",   int'(FROM_STACK), 10'h01F);
    step(1, 1, 10'h155, 0);
    chk("full_repl_top", int'(FROM_STACK), 10'h155);
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    chk("ovf_clr", int'(OVERFLOW), 0);

    // underflow and clear priority
    step(0, 1, '0, 0);
    chk("unf_flag",  int'(UNDERFLOW), 1);
    chk("unf_count", int'(COUNT), 0);
    step(0, 1, '0, 1);
    chk("unf_clr_lose", int'(UNDERFLOW), 1);
    step(0, 0, '0, 1);
    chk("unf_clr", int'(UNDERFLOW), 0);

    // replace top
    step(1, 0, 10'h005, 0);
    step(1, 0, 10'h010, 0);
    step(1, 1, 10'h200, 0);
    chk("repl_count", int'(COUNT), 2);
    chk("repl_top",   int'(FROM_STACK), 10'h200);
    chk("repl_flags", int'({OVERFLOW, UNDERFLOW}), 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(1, 1, 10'h200, 0);
    chk("erepl_count", int'(COUNT), 1);
    chk("erepl_top",   int'(FROM_STACK), 10'h200);
    chk("erepl_unf",   int'(UNDERFLOW), 1);
    step(0, 1, '0, 1);

    // interrupt entry and return
    step(1, 0, 10'h0A7, 0);
    pc_ld = 1;
    step(0, 1, '0, 0);
    pc_ld = 0;
    chk("ret_pc",    int'(pc), 10'h0A7);
    chk("ret_count", int'(COUNT), 0);

    // random traffic in push-heavy, pop-heavy and balanced phases
    for (int i = 0; i < 900; i++) begin
      case ((i / 100) % 3)
        0: pct = 85;
        1: pct = 20;
        default: pct = 50;
      endcase
      p = ($urandom_range(0, 99) < pct);
      q = ($urandom_range(0, 99) < (100 - pct));
      c = ($urandom_range(0, 99) < 6);
      step(p, q, PC_W'($urandom), c);
    end

    step(0, 0, '0, 0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
